// File: rtl/poly_eval_seq.sv
// Sequential Horner-method polynomial evaluator: operands are entered one per go press,
// then one multiply-accumulate per cycle produces c_D*x^D + ... + c_0 modulo 2^WIDTH.
module poly_eval_seq #(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            go,
    input  logic [WIDTH-1:0]                data_in,
    output logic [$clog2(DEGREE+2)-1:0]     load_idx,
    output logic                            busy,
    output logic [WIDTH-1:0]                result,
    output logic                            result_valid,
    output logic                            overflow
);

    localparam int IDX_W  = $clog2(DEGREE + 2);
    localparam int FULL_W = 2 * WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEGREE + 1);

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        LOAD_WAIT = 2'd1,
        COMPUTE   = 2'd2
    } state_t;

    state_t           state_r;
    // Slot k (0..DEGREE) holds c_(DEGREE-k); slot DEGREE+1 holds x.
    logic [WIDTH-1:0] ops_r [0:DEGREE+1];
    logic [WIDTH-1:0] acc_r;
    logic [IDX_W-1:0] step_r;
    logic [WIDTH-1:0] coef_s;
    logic [FULL_W-1:0] full_s;

    // Select c_step (held in slot DEGREE-step) with an AND-OR mux.
    always_comb begin
        coef_s = {WIDTH{1'b0}};
        for (int i = 0; i <= DEGREE; i++) begin
            coef_s = coef_s | (ops_r[i] & {WIDTH{step_r == IDX_W'(DEGREE - i)}});
        end
    end

    // One Horner step at full precision so any wrap can be detected.
    always_comb begin
        full_s = FULL_W'(acc_r) * FULL_W'(ops_r[DEGREE+1]) + FULL_W'(coef_s);
    end

    // Control FSM, operand capture and the multiply-accumulate datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= LOAD;
            load_idx     <= {IDX_W{1'b0}};
            busy         <= 1'b0;
            result       <= {WIDTH{1'b0}};
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            acc_r        <= {WIDTH{1'b0}};
            step_r       <= {IDX_W{1'b0}};
            for (int i = 0; i <= DEGREE + 1; i++) begin
                ops_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                LOAD: begin
                    if (go) begin
                        for (int i = 0; i <= DEGREE + 1; i++) begin
                            if (load_idx == IDX_W'(i)) begin
                                ops_r[i] <= data_in;
                            end
                        end
                        // First operand of a new evaluation retires the previous status.
                        if (load_idx == {IDX_W{1'b0}}) begin
                            result_valid <= 1'b0;
                            overflow     <= 1'b0;
                        end
                        state_r <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    if (!go) begin
                        if (load_idx == LAST_IDX) begin
                            acc_r   <= ops_r[0];
                            step_r  <= IDX_W'(DEGREE - 1);
                            busy    <= 1'b1;
                            state_r <= COMPUTE;
                        end else begin
                            load_idx <= load_idx + IDX_W'(1);
                            state_r  <= LOAD;
                        end
                    end
                end
                COMPUTE: begin
                    acc_r  <= full_s[WIDTH-1:0];
                    step_r <= step_r - IDX_W'(1);
                    if (|full_s[FULL_W-1:WIDTH]) begin
                        overflow <= 1'b1;
                    end
                    if (step_r == {IDX_W{1'b0}}) begin
                        result       <= full_s[WIDTH-1:0];
                        result_valid <= 1'b1;
                        load_idx     <= {IDX_W{1'b0}};
                        busy         <= 1'b0;
                        state_r      <= LOAD;
                    end
                end
                default: begin
                    state_r <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_eval_seq.sv
// Self-checking bench for poly_eval_seq: a degree-2 and a degree-3 instance (WIDTH=8)
// driven through a shared go/data_in steered by sel, checked against an arithmetic model.
module tb_poly_eval_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] data_in = 8'd0;

    logic       go_a, go_b;
    logic [1:0] idx_a;
    logic [2:0] idx_b;
    logic       busy_a, busy_b, rv_a, rv_b, ov_a, ov_b;
    logic [7:0] res_a, res_b;

    int   cur_idx, cur_res;
    logic cur_busy, cur_rv, cur_ov;

    int n_cmp = 0;
    int n_fail = 0;

    int cp [4];   // coefficient of x^i
    int xv;

    assign go_a = go & ~sel;
    assign go_b = go & sel;

    always #5 clk = ~clk;

    poly_eval_seq #(.WIDTH(8), .DEGREE(2)) u_d2 (
        .clk(clk), .reset(reset), .go(go_a), .data_in(data_in),
        .load_idx(idx_a), .busy(busy_a), .result(res_a),
        .result_valid(rv_a), .overflow(ov_a)
    );

    poly_eval_seq #(.WIDTH(8), .DEGREE(3)) u_d3 (
        .clk(clk), .reset(reset), .go(go_b), .data_in(data_in),
        .load_idx(idx_b), .busy(busy_b), .result(res_b),
        .result_valid(rv_b), .overflow(ov_b)
    );

    always_comb begin
        cur_idx  = sel ? int'(idx_b) : int'(idx_a);
        cur_res  = sel ? int'(res_b) : int'(res_a);
        cur_busy = sel ? busy_b : busy_a;
        cur_rv   = sel ? rv_b : rv_a;
        cur_ov   = sel ? ov_b : ov_a;
    end

    // Value as a sum of powers; overflow as "any untruncated Horner partial above 255".
    function automatic void ref_eval(input int deg, output int res, output logic ov);
        longint s = 0;
        longint p = 1;
        longint acc;
        longint full;
        for (int i = 0; i <= deg; i++) begin
            s = s + longint'(cp[i]) * p;
            p = (p * xv) % 256;
        end
        res = int'(s % 256);
        ov = 1'b0;
        acc = cp[deg];
        for (int i = deg - 1; i >= 0; i--) begin
            full = acc * xv + cp[i];
            if (full > 255) ov = 1'b1;
            acc = full % 256;
        end
    endfunction

    task automatic press(input int v, input int hold, input int gap);
        go = 1'b1;
        data_in = 8'(v);
        repeat (hold) @(negedge clk);
        go = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Enter slots first_k..deg (coefficients) then x; also tracks load_idx.
    task automatic enter_ops(input int deg, input int first_k);
        for (int k = first_k; k <= deg; k++) begin
            n_cmp++;
            if (cur_idx !== k) begin
                n_fail++;
                $display("FAIL load_idx_step: got %0d expected %0d", cur_idx, k);
            end
            press(cp[deg - k], 1, 1);
        end
        n_cmp++;
        if (cur_idx !== deg + 1) begin
            n_fail++;
            $display("FAIL load_idx_x: got %0d expected %0d", cur_idx, deg + 1);
        end
        press(xv, 1, 1);
    endtask

    // Called at cycle T+1; counts busy cycles and checks the completed evaluation.
    task automatic wait_result(input int deg, input string tag);
        int   exp_res;
        logic exp_ov;
        int   cnt = 0;
        ref_eval(deg, exp_res, exp_ov);
        while (cur_busy === 1'b1 && cnt < 20) begin
            n_cmp++;
            if (cur_rv !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_rv_during_busy: got %0b expected 0", tag, cur_rv);
            end
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt !== deg) begin
            n_fail++;
            $display("FAIL %s_busy_cycles: got %0d expected %0d", tag, cnt, deg);
        end
        n_cmp++;
        if (cur_rv !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_result_valid: got %0b expected 1", tag, cur_rv);
        end
        n_cmp++;
        if (cur_res !== exp_res) begin
            n_fail++;
            $display("FAIL %s_result: got %0d expected %0d", tag, cur_res, exp_res);
        end
        n_cmp++;
        if (cur_ov !== exp_ov) begin
            n_fail++;
            $display("FAIL %s_overflow: got %0b expected %0b", tag, cur_ov, exp_ov);
        end
        n_cmp++;
        if (cur_idx !== 0) begin
            n_fail++;
            $display("FAIL %s_idx_wrap: got %0d expected 0", tag, cur_idx);
        end
    endtask

    task automatic randomize_ops(input int deg);
        for (int i = 0; i < 4; i++) cp[i] = (i <= deg) ? int'($urandom_range(0, 255)) : 0;
        xv = int'($urandom_range(0, 255));
    endtask

    task automatic check_reset_state(input string tag);
        n_cmp++;
        if (cur_idx !== 0 || cur_busy !== 1'b0 || cur_res !== 0 || cur_rv !== 1'b0 || cur_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got idx=%0d busy=%0b res=%0d rv=%0b ov=%0b expected all 0",
                     tag, cur_idx, cur_busy, cur_res, cur_rv, cur_ov);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        check_reset_state("reset_d2");
        sel = 1'b1;
        check_reset_state("reset_d3");
        sel = 1'b0;
    endtask

    task automatic test_basic();
        sel = 1'b0;
        cp[2] = 3; cp[1] = 2; cp[0] = 1; xv = 4;
        enter_ops(2, 0);
        wait_result(2, "basic");
        n_cmp++;
        if (cur_res !== 57) begin
            n_fail++;
            $display("FAIL basic_57: got %0d expected 57", cur_res);
        end
    endtask

    task automatic test_overflow();
        sel = 1'b0;
        cp[2] = 16; cp[1] = 0; cp[0] = 0; xv = 5;
        enter_ops(2, 0);
        wait_result(2, "ovf");
        cp[2] = 0;
        cp[1] = int'($urandom_range(0, 255));
        cp[0] = int'($urandom_range(0, 255));
        xv = int'($urandom_range(0, 15));
        go = 1'b1;
        data_in = 8'd0;
        @(negedge clk);
        n_cmp++;
        if (cur_rv !== 1'b0 || cur_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got rv=%0b ov=%0b expected 0 0", cur_rv, cur_ov);
        end
        n_cmp++;
        if (cur_res !== 144) begin
            n_fail++;
            $display("FAIL ovf_result_hold: got %0d expected 144", cur_res);
        end
        go = 1'b0;
        @(negedge clk);
        enter_ops(2, 1);
        wait_result(2, "ovf_next");
    endtask

    task automatic test_degree3();
        sel = 1'b1;
        cp[3] = 1; cp[2] = 0; cp[1] = 0; cp[0] = 7; xv = 3;
        enter_ops(3, 0);
        wait_result(3, "deg3");
        n_cmp++;
        if (cur_res !== 34) begin
            n_fail++;
            $display("FAIL deg3_34: got %0d expected 34", cur_res);
        end
    endtask

    task automatic test_long_press();
        sel = 1'b0;
        cp[2] = 5;
        cp[1] = int'($urandom_range(0, 255));
        cp[0] = int'($urandom_range(0, 255));
        xv = int'($urandom_range(0, 255));
        go = 1'b1;
        data_in = 8'd5;
        @(negedge clk);
        data_in = 8'd9;
        repeat (4) @(negedge clk);
        data_in = 8'd200;
        repeat (5) @(negedge clk);
        go = 1'b0;
        repeat (21) @(negedge clk);
        n_cmp++;
        if (cur_idx !== 1) begin
            n_fail++;
            $display("FAIL long_press_idx: got %0d expected 1", cur_idx);
        end
        enter_ops(2, 1);
        wait_result(2, "long_press");
    endtask

    task automatic test_reset_mid();
        sel = 1'b1;
        randomize_ops(3);
        enter_ops(3, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("reset_mid");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cur_rv !== 1'b0 || cur_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got rv=%0b busy=%0b expected 0 0", cur_rv, cur_busy);
        end
        randomize_ops(3);
        enter_ops(3, 0);
        wait_result(3, "after_reset");
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        randomize_ops(2);
        enter_ops(2, 0);
        wait_result(2, "b2b_first");
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (cur_rv !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_rv_hold: got %0b expected 1", cur_rv);
            end
            @(negedge clk);
        end
        randomize_ops(2);
        enter_ops(2, 0);
        wait_result(2, "b2b_second");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            sel = n[0];
            randomize_ops(sel ? 3 : 2);
            enter_ops(sel ? 3 : 2, 0);
            wait_result(sel ? 3 : 2, "random");
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_basic();
        test_overflow();
        test_degree3();
        test_long_press();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/poly_eval_seq.md
# poly_eval_seq

Sequential polynomial evaluator. It is the parametrised successor of the fixed Ax²+Bx+C lab datapath/control pair. Operands are entered one at a time on `data_in` with a `go` press/release handshake. The block then evaluates c_D·x^D + … + c_1·x + c_0 by Horner's method, performing one multiply-accumulate per cycle. Width and polynomial degree are parameters, and a sticky overflow flag reports when any intermediate step wrapped.

## Interface
- `WIDTH`, default 8: bit width of coefficients, x, accumulator and result (≥2).
- `DEGREE`, default 2: polynomial degree D (≥1). The block stores D+1 coefficients.
- `clk`: input, 1 bit. Clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high reset.
- `go`: input, 1 bit. Operand-entry strobe, level-sensitive press/release.
- `data_in`: input, `WIDTH` bits. Operand value, captured on press.
- `load_idx`: output, $clog2(DEGREE+2) bits. Slot awaiting entry. 0..D selects c_D..c_0; D+1 selects x.
- `busy`: output, 1 bit. High while in COMPUTE.
- `result`: output, `WIDTH` bits. Registered polynomial value, modulo 2^WIDTH.
- `result_valid`: output, 1 bit. High while `result` holds a fresh, unconsumed value.
- `overflow`: output, 1 bit. Sticky. Set if any Horner step exceeded 2^WIDTH−1.

## Operation
- **Entry order:** c_D, c_{D−1}, …, c_0, then x. That is D+2 operands per evaluation.
- **FSM states:** LOAD, LOAD_WAIT, COMPUTE.
- **LOAD:**
  - If `go`=1 is sampled, store `data_in` into slot `load_idx` and go to LOAD_WAIT.
  - Otherwise stay in LOAD.
  - The captured value is `data_in` in the first cycle `go` is high. Later changes while `go` is held are ignored.
- **LOAD_WAIT:**
  - Stay while `go`=1.
  - When `go`=0 and `load_idx`<D+1: increment `load_idx` and return to LOAD.
  - When `go`=0 and `load_idx`=D+1: set acc←c_D, step←D−1, go to COMPUTE.
- **COMPUTE:**
  - Each cycle, compute full = acc·x + c_step at 2·WIDTH+1 bits.
  - acc ← full[WIDTH−1:0].
  - If full ≥ 2^WIDTH, set `overflow`.
  - Decrement step.
  - On the step=0 cycle: write the truncated sum into `result` (not acc), set `result_valid`, clear `load_idx`, go to LOAD.
  - `go` is ignored in COMPUTE.
- **Clearing on a new evaluation:** the first `go` sampled high in LOAD with `load_idx`=0 clears `result_valid` and `overflow` in that same edge. `result` keeps its previous value until the next completion.
- **Operand registers:** coefficient and x registers keep their values between evaluations. Every slot is rewritten on each evaluation.
- **Arithmetic:** unsigned, all modulo 2^WIDTH. `overflow` is unsigned-only; there is no signed mode.

## Timing
- **Reset values:** state=LOAD, `load_idx`=0, `busy`=0, `result`=0, `result_valid`=0, `overflow`=0. acc, step and operand registers are 0.
- **Reset priority:** reset takes priority in any state, including mid-COMPUTE. The partial evaluation is discarded and no `result_valid` is produced.
- **Latency:**
  - Let T be the cycle in which LOAD_WAIT samples `go`=0 for slot D+1.
  - COMPUTE occupies cycles T+1 … T+D, with `busy`=1 exactly in those cycles.
  - `result` and `result_valid` are updated at the end of cycle T+D, so they are visible from cycle T+D+1.
- **Minimum go timing:** a press of one cycle high followed by one cycle low is a complete entry. Minimum time for a full evaluation is 2(D+2)+D cycles.
- **go held high across COMPUTE end:** the first LOAD cycle samples `go`=1 and captures c_D immediately. This also clears `result_valid` in that edge, so `result_valid` may be high for a single cycle. Callers must release `go` before COMPUTE ends to avoid this.
- **`load_idx` wrap:** `load_idx` never exceeds D+1. It returns to 0 only via completion or reset.

## Test plan
- **Basic evaluation (WIDTH=8, D=2):** enter 3, 2, 1, x=4 → `result`=57, `overflow`=0. `busy` is high for exactly 2 cycles and `result_valid` rises at T+3.
- **Overflow (WIDTH=8, D=2):** enter 16, 0, 0, x=5 → `result`=144 (400 mod 256), `overflow`=1. On the next evaluation's first press (c_2=0), `overflow` and `result_valid` drop in the same edge. `result` stays 144 until that evaluation completes.
- **Higher degree (D=3):** enter 1, 0, 0, 7, x=3 → `result`=34, `busy` high for exactly 3 cycles. Also check `load_idx` steps 0→1→2→3→4→0.
- **Long press:** hold `go` high for 10 cycles while `data_in` changes 5→9→200. The captured slot equals 5. Holding `go` low for 20 cycles in LOAD does not advance `load_idx`.
- **Reset mid-COMPUTE (D=3):** assert `reset` in the second COMPUTE cycle → next cycle shows state LOAD, `load_idx`=0, `busy`=0, `result`=0, `result_valid`=0. A following clean evaluation produces the correct value.
- **Back-to-back evaluations:** run two evaluations with `go` released before COMPUTE ends. `result_valid` stays high between them until the first press, and the second result is correct.
